mergesort_main: RTL and testbench

Self-contained hardware mergesort accelerator with internal data storage and a byte-wide dual-channel slave memory port. On a start pulse it sorts a 32-entry array of signed 8-bit values in place, ascending, then pulses done. It is the top-level kernel in the HLS-style benchmark flow; the bench only starts it, counts cycles to done, and may inspect memory through the slave port.

---
 rtl/mergesort_main.sv | 139 +++++++++++++
 tb/tb_mergesort_main.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mergesort_main.sv
// In-place bottom-up mergesort of 32 signed bytes held in internal registers,
// with a byte-wide dual-channel slave port for host access to the A and T buffers.
module mergesort_main #(
  parameter int MEM_var_28859_28863 = 64,
  parameter int MEM_var_28861_28867 = 32,
  parameter int MEM_var_29027_28863 = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  input  logic [1:0]  S_oe_ram,
  input  logic [1:0]  S_we_ram,
  input  logic [13:0] S_addr_ram,
  input  logic [15:0] S_Wdata_ram,
  input  logic [7:0]  S_data_ram_size,
  output logic        done_port,
  output logic [15:0] Sout_Rdata_ram,
  output logic [1:0]  Sout_DataRdy
);
  localparam int DATA_W = 8;
  localparam int N      = 32;
  localparam int BASE_A = MEM_var_28859_28863;
  localparam int BASE_T = MEM_var_28861_28867;

  typedef enum logic [2:0] {IDLE, SETUP, MERGE, COPY, DONE} state_t;

  state_t state;
  logic signed [DATA_W-1:0] a_mem [N];
  logic signed [DATA_W-1:0] t_mem [N];
  logic [5:0] width, k, l, r, lend, rend;
  logic       take_left;

  logic [6:0]        addr    [2];
  logic [4:0]        idx_a   [2];
  logic [4:0]        idx_t   [2];
  logic [1:0]        hit_a, hit_t;
  logic [DATA_W-1:0] rd_byte [2];

  // Access size is fixed at one byte; the reserved base is not decoded.
  logic unused_sig;
  assign unused_sig = ^{S_data_ram_size, (MEM_var_29027_28863 != 0)};

  // Left run wins ties, which keeps the merge stable.
  always_comb begin
    take_left = (l < lend) && ((r >= rend) || (a_mem[l[4:0]] <= a_mem[r[4:0]]));
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      addr[c]    = S_addr_ram[7*c +: 7];
      hit_a[c]   = (int'(addr[c]) >= BASE_A) && (int'(addr[c]) < BASE_A + N);
      hit_t[c]   = (int'(addr[c]) >= BASE_T) && (int'(addr[c]) < BASE_T + N);
      idx_a[c]   = 5'(addr[c] - 7'(BASE_A));
      idx_t[c]   = 5'(addr[c] - 7'(BASE_T));
      rd_byte[c] = '0;
      if (hit_a[c])      rd_byte[c] = a_mem[idx_a[c]];
      else if (hit_t[c]) rd_byte[c] = t_mem[idx_t[c]];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      done_port      <= 1'b0;
      Sout_DataRdy   <= '0;
      Sout_Rdata_ram <= '0;
      width          <= 6'd1;
      k              <= '0;
      l              <= '0;
      r              <= '0;
      lend           <= '0;
      rend           <= '0;
      for (int i = 0; i < N; i++) begin
        a_mem[i] <= DATA_W'((13 * i + 7) % 32 - 16);
        t_mem[i] <= '0;
      end
    end else begin
      done_port <= 1'b0;
      case (state)
        IDLE: begin
          if (start_port) begin
            width <= 6'd1;
            state <= SETUP;
          end
        end
        SETUP: begin
          k     <= '0;
          l     <= '0;
          r     <= width;
          lend  <= width;
          rend  <= width << 1;
          state <= MERGE;
        end
        MERGE: begin
          t_mem[k[4:0]] <= take_left ? a_mem[l[4:0]] : a_mem[r[4:0]];
          if (take_left) l <= l + 6'd1;
          else           r <= r + 6'd1;
          // Last element of this run pair: open the next pair of runs.
          if (k + 6'd1 == rend) begin
            l    <= rend;
            r    <= rend + width;
            lend <= rend + width;
            rend <= rend + (width << 1);
          end
          k <= k + 6'd1;
          if (k == 6'd31) begin
            k     <= '0;
            state <= COPY;
          end
        end
        COPY: begin
          a_mem[k[4:0]] <= t_mem[k[4:0]];
          k <= k + 6'd1;
          if (k == 6'd31) begin
            if (width == 6'd16) begin
              state     <= DONE;
              done_port <= 1'b1;
            end else begin
              width <= width << 1;
              state <= SETUP;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Channel 1 is handled last so it wins a same-address write collision.
      for (int c = 0; c < 2; c++) begin
        Sout_DataRdy[c]        <= S_oe_ram[c] | S_we_ram[c];
        Sout_Rdata_ram[8*c +: 8] <= (S_oe_ram[c] && !S_we_ram[c]) ? rd_byte[c] : 8'h00;
        if (S_we_ram[c] && state == IDLE) begin
          if (hit_a[c])      a_mem[idx_a[c]] <= S_Wdata_ram[8*c +: 8];
          else if (hit_t[c]) t_mem[idx_t[c]] <= S_Wdata_ram[8*c +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_mergesort_main.sv
// Directed/randomised bench for mergesort_main against a queue-free array
// reference model that sorts with a plain insertion sort.
module tb_mergesort_main;
  logic        clock = 1'b0;
  logic        reset;
  logic        start_port;
  logic [1:0]  S_oe_ram, S_we_ram;
  logic [13:0] S_addr_ram;
  logic [15:0] S_Wdata_ram;
  logic [7:0]  S_data_ram_size;
  logic        done_port;
  logic [15:0] Sout_Rdata_ram;
  logic [1:0]  Sout_DataRdy;

  int tests  = 0;
  int failed = 0;
  int cyc;
  int dones;
  logic signed [7:0] ref_a [32];
  logic signed [7:0] ref_t [32];
  logic signed [7:0] pat   [32];

  mergesort_main dut (
    .clock          (clock),
    .reset          (reset),
    .start_port     (start_port),
    .S_oe_ram       (S_oe_ram),
    .S_we_ram       (S_we_ram),
    .S_addr_ram     (S_addr_ram),
    .S_Wdata_ram    (S_Wdata_ram),
    .S_data_ram_size(S_data_ram_size),
    .done_port      (done_port),
    .Sout_Rdata_ram (Sout_Rdata_ram),
    .Sout_DataRdy   (Sout_DataRdy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    S_oe_ram        = 2'b00;
    S_we_ram        = 2'b00;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = 8'h88;
  endtask

  task automatic access(input logic [1:0] oe, input logic [1:0] we,
                        input logic [6:0] a0, input logic [6:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1);
    S_oe_ram    = oe;
    S_we_ram    = we;
    S_addr_ram  = {a1, a0};
    S_Wdata_ram = {d1, d0};
    step();
    idle_bus();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      ref_a[i] = 8'(((13 * i + 7) % 32) - 16);
      ref_t[i] = 8'sd0;
    end
  endtask

  // Result is the ascending permutation; the final merge pass leaves it in T too.
  task automatic model_sort();
    logic signed [7:0] v;
    int j;
    for (int i = 1; i < 32; i++) begin
      v = ref_a[i];
      j = i - 1;
      while (j >= 0 && ref_a[j] > v) begin
        ref_a[j + 1] = ref_a[j];
        j--;
      end
      ref_a[j + 1] = v;
    end
    for (int i = 0; i < 32; i++) ref_t[i] = ref_a[i];
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 32; i += 2) begin
      access(2'b11, 2'b00, 7'(64 + i), 7'(65 + i), 8'h00, 8'h00);
      check({tag, "_a_rdy"}, 32'(Sout_DataRdy), 32'h3);
      check({tag, "_a0"}, 32'(Sout_Rdata_ram[7:0]),  32'($unsigned(ref_a[i])));
      check({tag, "_a1"}, 32'(Sout_Rdata_ram[15:8]), 32'($unsigned(ref_a[i + 1])));
      access(2'b11, 2'b00, 7'(32 + i), 7'(33 + i), 8'h00, 8'h00);
      check({tag, "_t0"}, 32'(Sout_Rdata_ram[7:0]),  32'($unsigned(ref_t[i])));
      check({tag, "_t1"}, 32'(Sout_Rdata_ram[15:8]), 32'($unsigned(ref_t[i + 1])));
    end
  endtask

  task automatic load_pat();
    for (int i = 0; i < 32; i += 2) begin
      access(2'b00, 2'b11, 7'(64 + i), 7'(65 + i), pat[i], pat[i + 1]);
      ref_a[i]     = pat[i];
      ref_a[i + 1] = pat[i + 1];
    end
  endtask

  task automatic run_sort(input string tag, input bit extras);
    int cnt;
    start_port = 1'b1;
    step();
    start_port = 1'b0;
    cnt = 1;
    while (done_port !== 1'b1 && cnt < 400) begin
      start_port = extras && (cnt == 50 || cnt == 325);
      if (extras && cnt == 100) begin
        S_we_ram    = 2'b01;
        S_addr_ram  = 14'd70;
        S_Wdata_ram = 16'h007F;
      end else begin
        idle_bus();
      end
      step();
      cnt++;
      if (extras && cnt == 101) begin
        check({tag, "_busy_wr_ack"}, 32'(Sout_DataRdy), 32'h1);
        check({tag, "_busy_wr_rdata"}, 32'(Sout_Rdata_ram), 32'h0);
      end
    end
    start_port = extras;
    idle_bus();
    check({tag, "_done_latency"}, 32'(cnt), 32'd326);
    check({tag, "_done_high"}, 32'(done_port), 32'h1);
    step();
    start_port = 1'b0;
    check({tag, "_done_one_cycle"}, 32'(done_port), 32'h0);
    model_sort();
    if (extras) begin
      dones = 0;
      for (int i = 0; i < 340; i++) begin
        step();
        if (done_port === 1'b1) dones++;
      end
      check({tag, "_no_second_done"}, 32'(dones), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start_port = 1'b0;
    idle_bus();
    step();
    step();
    reset = 1'b0;
    model_reset();
    check("rst_done", 32'(done_port), 32'h0);
    check("rst_rdy", 32'(Sout_DataRdy), 32'h0);
    check("rst_rdata", 32'(Sout_Rdata_ram), 32'h0);
    read_all("rst_pattern");

    // Same-address write collision, write-over-read, and unmapped addresses.
    access(2'b00, 2'b11, 7'd70, 7'd70, 8'h11, 8'h22);
    ref_a[6] = 8'sh22;
    access(2'b01, 2'b01, 7'd71, 7'd0, 8'h33, 8'h00);
    ref_a[7] = 8'sh33;
    check("rw_both_rdy", 32'(Sout_DataRdy), 32'h1);
    check("rw_both_rdata", 32'(Sout_Rdata_ram), 32'h0);
    access(2'b01, 2'b10, 7'd120, 7'd10, 8'h00, 8'h55);
    check("oob_rdy", 32'(Sout_DataRdy), 32'h3);
    check("oob_rdata", 32'(Sout_Rdata_ram), 32'h0);
    access(2'b01, 2'b00, 7'd10, 7'd0, 8'h00, 8'h00);
    check("oob_wr_ignored", 32'(Sout_Rdata_ram), 32'h0);
    check("idle_rdy_clear", 32'(Sout_DataRdy), 32'h1);
    step();
    check("rdy_drops", 32'(Sout_DataRdy), 32'h0);
    read_all("collide");

    run_sort("perm", 1'b1);
    read_all("perm_sorted");

    for (int i = 0; i < 32; i++) pat[i] = 8'($urandom_range(0, 255));
    load_pat();
    run_sort("rand_wide", 1'b0);
    read_all("rand_wide");

    for (int i = 0; i < 32; i++) pat[i] = 8'(int'($urandom_range(0, 4)) - 2);
    load_pat();
    run_sort("rand_dups", 1'b0);
    read_all("rand_dups");

    run_sort("presorted", 1'b0);
    read_all("presorted");

    for (int i = 0; i < 32; i++) pat[i] = 8'sh05;
    load_pat();
    run_sort("all_equal", 1'b0);
    read_all("all_equal");

    for (int i = 0; i < 32; i++) pat[i] = 8'(15 - i);
    load_pat();
    run_sort("descending", 1'b0);
    read_all("descending");

    // Abort a run with reset, then confirm a clean restart.
    for (int i = 0; i < 32; i++) pat[i] = 8'($urandom_range(0, 255));
    load_pat();
    start_port = 1'b1;
    step();
    start_port = 1'b0;
    for (int i = 1; i < 100; i++) step();
    reset = 1'b1;
    start_port = 1'b1;
    step();
    reset = 1'b0;
    start_port = 1'b0;
    check("abort_done", 32'(done_port), 32'h0);
    check("abort_rdy", 32'(Sout_DataRdy), 32'h0);
    dones = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (done_port === 1'b1) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    model_reset();
    read_all("abort_reload");
    run_sort("after_abort", 1'b0);
    read_all("after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
